ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- INHIBIT_CYCLES, 5000, clk cycles that ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum clk cycles between device clock falling edges, or until bus release, before abort.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock; all logic is on its rising edge.
- rst, in, 1, synchronous, active-low reset.
- tx_data, in, 8, command byte for the device.
- tx_valid, in, 1, request to send tx_data.
- tx_ready, out, 1, block is idle and accepts a request.
- ps2_clk_in, in, 1, raw (asynchronous) PS/2 clock line level.
- ps2_data_in, in, 1, raw (asynchronous) PS/2 data line level.
- ps2_clk_oe, out, 1, 1 = drive the PS/2 clock line low; 0 = release it.
- ps2_data_oe, out, 1, 1 = drive the PS/2 data line low; 0 = release it.
- done, out, 1, one-cycle pulse at the end of every accepted transfer.
- ack_ok, out, 1, qualified by done: 1 = the device acknowledged the byte.
- timeout, out, 1, qualified by done: 1 = the transfer was aborted by timeout.

Function
REQ-003 ps2_clk_in and ps2_data_in SHALL pass through a 2-flop synchronizer; a device clock falling edge ("fe") is synchronized clock 1 in the previous cycle and 0 in this cycle.
REQ-004 State machine states SHALL be IDLE, INHIBIT, REQ, SEND, ACK, RELEASE.
REQ-005 IDLE: tx_ready=1, both oe=0; on tx_valid&&tx_ready the block latches tx_data, computes the odd parity bit (~^tx_data) and enters INHIBIT on the next cycle.
REQ-006 tx_ready SHALL be 0 in every state except IDLE; tx_valid outside IDLE is ignored and never queued.
REQ-007 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles; the block then sets ps2_data_oe=1 (start bit) in the same cycle it releases ps2_clk_oe, and enters REQ.
REQ-008 REQ: data is held low and the clock released; the first fe drives bit0 and enters SEND with bit count 1.
REQ-009 SEND: each fe advances one frame bit, LSB first.
- fe 2..8: data bits 1..7.
- fe 9: parity bit.
- fe 10: stop bit (data released), then the block enters ACK.
- ps2_data_oe = ~bit_value throughout.
REQ-010 ACK: on fe 11 the block samples synchronized data; low gives ack_ok=1, high gives ack_ok=0. The block then enters RELEASE.
REQ-011 RELEASE: the block waits for both synchronized lines to be high, then pulses done for 1 cycle with ack_ok and timeout valid, and returns to IDLE.
REQ-012 A timeout counter SHALL clear on entry to REQ and on every fe. If it reaches TIMEOUT_CYCLES in REQ, SEND, ACK or RELEASE, the block:
- releases both lines in the next cycle;
- pulses done with timeout=1 and ack_ok=0;
- returns to IDLE.
REQ-013 ack_ok and timeout SHALL hold their values until the next done pulse; done is never asserted outside the cycle defined above.
REQ-014 Output latency: tx_ready falls 1 cycle after acceptance; ps2_clk_oe rises in that same cycle.

Reset
REQ-015 On rst==0 at a clk edge the following SHALL occur, in any state, including mid-frame:
- state is IDLE;
- ps2_clk_oe=0, ps2_data_oe=0;
- done=0, ack_ok=0, timeout=0;
- tx_ready=1 from the first cycle after rst returns to 1;
- counters and synchronizer flops are cleared; the synchronizer flops reset to 1 (idle bus).

Structure
REQ-016 Package ps2_pkg SHALL hold the state enum, FRAME_FES=10 and ACK_FE=11, and is shared with the PS/2 receiver.
REQ-017 Sub-module ps2_sync_edge (2-flop synchronizer plus fe detect, one instance per line) SHALL be factored out for reuse by the receiver.

Verification
REQ-018 The bench SHALL use INHIBIT_CYCLES=8 and TIMEOUT_CYCLES=200, with a device model that clocks at 20-cycle half periods. It SHALL cover:
- Send 0xED, device acks -> bits observed 1,0,1,1,0,1,1,1, parity 1, stop 1; done with ack_ok=1, timeout=0.
- Send 0xF4, device leaves data high at fe 11 -> parity 0; done with ack_ok=0.
- Send 0x00 with the device never clocking -> 200 cycles after REQ entry: both oe=0, done with timeout=1.
- tx_valid held during transfer of 0xFF -> exactly one done pulse; second byte not sent until tx_ready=1 again.
- rst=0 at SEND bit 4 -> next cycle both oe=0 and tx_ready=1 after release; a following 0xAA transfer completes with ack_ok=1.
- Check ps2_clk_oe high for exactly 8 cycles, with data_oe rising in the same cycle clock_oe falls.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: state encoding, frame edge counts and the parity helper
// used by both the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SEND    = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } ps2_state_e;

  localparam int unsigned FRAME_FES = 10;
  localparam int unsigned ACK_FE    = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line with falling-edge detect on the
// synchronized level. Flops reset to 1 so an idle bus never looks like an edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fe
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw line through the synchronizer and keep one cycle of history.
  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and history registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign fe    = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts
// out data/parity/stop on device clock falling edges and collects the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_FES - 1);

  logic clk_level, clk_fe;
  logic data_level, data_fe;

  ps2_sync_edge u_sync_clk (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk_in),
    .level   (clk_level),
    .fe      (clk_fe)
  );

  ps2_sync_edge u_sync_data (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_data_in),
    .level   (data_level),
    .fe      (data_fe)
  );

  ps2_state_e       state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_ready_q, tx_ready_d;
  logic             done_q, done_d;
  logic             ack_ok_q, ack_ok_d;
  logic             timeout_q, timeout_d;
  logic             ack_bit_q, ack_bit_d;

  // Next-state and registered-output logic; one counter serves both inhibit and timeout.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    tx_ready_d = tx_ready_q;
    done_d     = 1'b0;
    ack_ok_d   = ack_ok_q;
    timeout_d  = timeout_q;
    ack_bit_d  = ack_bit_q;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          frame_d    = {1'b1, odd_parity(tx_data), tx_data};
          cnt_d      = '0;
          clk_oe_d   = 1'b1;
          tx_ready_d = 1'b0;
          state_d    = ST_INHIBIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          // Start bit goes out in the same cycle the clock is released.
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_REQ, ST_SEND, ST_ACK, ST_RELEASE: begin
        if (cnt_q == TMO_LAST) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          done_d     = 1'b1;
          ack_ok_d   = 1'b0;
          timeout_d  = 1'b1;
          tx_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          if (clk_fe) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          case (state_q)
            ST_REQ: begin
              if (clk_fe) begin
                data_oe_d = ~frame_q[0];
                bit_cnt_d = 4'd1;
                state_d   = ST_SEND;
              end else begin
                data_oe_d = 1'b1;
              end
            end
            ST_SEND: begin
              if (clk_fe) begin
                data_oe_d = ~frame_q[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_ACK;
                end else begin
                  state_d = ST_SEND;
                end
              end else begin
                data_oe_d = data_oe_q;
              end
            end
            ST_ACK: begin
              if (clk_fe) begin
                ack_bit_d = ~data_level;
                bit_cnt_d = 4'(ACK_FE);
                state_d   = ST_RELEASE;
              end else begin
                ack_bit_d = ack_bit_q;
              end
            end
            ST_RELEASE: begin
              if (clk_level && data_level) begin
                done_d     = 1'b1;
                ack_ok_d   = ack_bit_q;
                timeout_d  = 1'b0;
                tx_ready_d = 1'b1;
                state_d    = ST_IDLE;
              end else begin
                state_d = ST_RELEASE;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      default: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      frame_q    <= 10'd0;
      bit_cnt_q  <= 4'd0;
      cnt_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      timeout_q  <= 1'b0;
      ack_bit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      timeout_q  <= timeout_d;
      ack_bit_q  <= ack_bit_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign timeout     = timeout_q;

  logic unused_data_fe;
  assign unused_data_fe = data_fe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-collector bus model, a PS/2 device
// that clocks with 20-cycle half periods, and a frame model built from byte arithmetic.
module tb_ps2_host_tx;

  localparam int INH  = 8;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       done, ack_ok, timeout;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int errors = 0;
  int checks = 0;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .ack_ok      (ack_ok),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: data LSB first, odd parity from a count of ones, stop bit 1.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones;
    logic [9:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = b[i];
      if (b[i]) ones++;
    end
    f[8] = ((ones % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic request(input string tag, input logic [7:0] b);
    check({tag, "_ready_before"}, tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, "_ready_fall"}, tx_ready, 1'b0);
    check({tag, "_clk_oe_rise"}, ps2_clk_oe, 1'b1);
  endtask

  task automatic inhibit_check(input string tag);
    int n;
    logic data_during;
    n = 0;
    data_during = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < 100) begin
      data_during = data_during | ps2_data_oe;
      @(negedge clk);
      n++;
    end
    check({tag, "_inh_len"}, n, INH);
    check({tag, "_inh_data"}, data_during, 1'b0);
    check({tag, "_start_bit"}, ps2_data_oe, 1'b1);
  endtask

  task automatic device_frame(input string tag, input int n_fe, input bit ack_low,
                              output logic [9:0] seen, output int done_seen);
    int guard;
    seen = 10'd0;
    done_seen = 0;
    guard = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_req_seen"}, (guard < 100), 1'b1);
    for (int k = 1; k <= n_fe; k++) begin
      repeat (HALF) begin
        @(negedge clk);
        if (done === 1'b1) done_seen++;
      end
      if (k == 11 && ack_low) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) begin
        @(negedge clk);
        if (done === 1'b1) done_seen++;
      end
      if (k <= 10) seen[k-1] = ps2_data_in;
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input string tag, input int max, output logic a, output logic t);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_ready_at_done"}, tx_ready, 1'b1);
    a = ack_ok;
    t = timeout;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] b, input bit ack_low);
    logic [9:0] seen;
    int dn;
    logic a, t;
    request(tag, b);
    inhibit_check(tag);
    device_frame(tag, 11, ack_low, seen, dn);
    check({tag, "_frame"}, seen, model_frame(b));
    check({tag, "_early_done"}, dn, 0);
    wait_done(tag, 200, a, t);
    check({tag, "_ack"}, a, ack_low);
    check({tag, "_tmo"}, t, 1'b0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 1'b0);
  endtask

  initial begin
    logic [9:0] seen;
    int dn;
    logic a, t;
    logic [7:0] rb;
    bit rack;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack", ack_ok, 1'b0);
    check("rst_tmo", timeout, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_after", tx_ready, 1'b1);

    // 0xED acked: explicit bit pattern plus model
    request("ed", 8'hED);
    inhibit_check("ed");
    device_frame("ed", 11, 1'b1, seen, dn);
    check("ed_bits", seen[7:0], 8'b1110_1101);
    check("ed_parity", seen[8], 1'b1);
    check("ed_stop", seen[9], 1'b1);
    check("ed_frame", seen, model_frame(8'hED));
    check("ed_early_done", dn, 0);
    wait_done("ed", 200, a, t);
    check("ed_ack", a, 1'b1);
    check("ed_tmo", t, 1'b0);
    @(negedge clk);
    check("ed_done_1cyc", done, 1'b0);
    repeat (5) @(negedge clk);
    check("ed_ack_hold", ack_ok, 1'b1);

    // 0xF4, device never acks
    request("f4", 8'hF4);
    inhibit_check("f4");
    device_frame("f4", 11, 1'b0, seen, dn);
    check("f4_parity", seen[8], 1'b0);
    check("f4_frame", seen, model_frame(8'hF4));
    wait_done("f4", 200, a, t);
    check("f4_ack", a, 1'b0);
    check("f4_tmo", t, 1'b0);

    // 0x00 with a silent device: abort 200 cycles after REQ entry
    @(negedge clk);
    request("to", 8'h00);
    inhibit_check("to");
    repeat (TMO - 1) @(negedge clk);
    check("to_data_before", ps2_data_oe, 1'b1);
    check("to_done_before", done, 1'b0);
    @(negedge clk);
    check("to_clk_oe", ps2_clk_oe, 1'b0);
    check("to_data_oe", ps2_data_oe, 1'b0);
    check("to_done", done, 1'b1);
    check("to_tmo", timeout, 1'b1);
    check("to_ack", ack_ok, 1'b0);
    @(negedge clk);
    check("to_done_1cyc", done, 1'b0);
    check("to_ready", tx_ready, 1'b1);
    check("to_tmo_hold", timeout, 1'b1);

    // 0xFF with tx_valid held across the transfer
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    check("hold_ready_fall", tx_ready, 1'b0);
    check("hold_clk_oe", ps2_clk_oe, 1'b1);
    inhibit_check("hold");
    tx_data = 8'h5A;
    device_frame("hold", 11, 1'b1, seen, dn);
    check("hold_frame", seen, model_frame(8'hFF));
    check("hold_early_done", dn, 0);
    wait_done("hold", 200, a, t);
    check("hold_ack", a, 1'b1);
    check("hold_tmo_clear", t, 1'b0);
    @(negedge clk);
    check("hold_done_1cyc", done, 1'b0);
    check("hold_second_start", ps2_clk_oe, 1'b1);
    check("hold_second_busy", tx_ready, 1'b0);
    tx_valid = 1'b0;
    inhibit_check("hold2");
    device_frame("hold2", 11, 1'b1, seen, dn);
    check("hold2_frame", seen, model_frame(8'h5A));
    check("hold2_early_done", dn, 0);
    wait_done("hold2", 200, a, t);
    check("hold2_ack", a, 1'b1);
    @(negedge clk);

    // Reset mid-frame, then a clean 0xAA transfer
    request("mid", 8'h3C);
    inhibit_check("mid");
    device_frame("mid", 4, 1'b0, seen, dn);
    check("mid_bits", seen[3:0], 4'hC);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_clk_oe", ps2_clk_oe, 1'b0);
    check("mid_data_oe", ps2_data_oe, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_ack", ack_ok, 1'b0);
    check("mid_tmo", timeout, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_ready", tx_ready, 1'b1);
    run_xfer("aa", 8'hAA, 1'b1);

    // Randomized bytes and ack responses
    for (int i = 0; i < 4; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      run_xfer($sformatf("rnd%0d", i), rb, rack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
